// File: rtl/uart_periph.sv
// Memory-mapped UART: TXD/RXD/CON registers, 8N1 transmitter and receiver,
// level interrupt derived from the sticky status bits and their enables.
module uart_periph #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [31:0] TXD_ADDR = BASE_ADDR + 32'd24;
  localparam logic [31:0] RXD_ADDR = BASE_ADDR + 32'd28;
  localparam logic [31:0] CON_ADDR = BASE_ADDR + 32'd32;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_ferr;
  logic          rx_s1, rx_s2, rx_prev;
  logic [7:0]    rxd;

  logic con_txie, con_rxie, tx_done, rx_ready;

  logic sel_txd, sel_rxd, sel_con, con_wr;
  logic tx_busy, tx_finish, rx_finish;
  logic unused_bits;

  assign sel_txd = (addr[31:2] == TXD_ADDR[31:2]);
  assign sel_rxd = (addr[31:2] == RXD_ADDR[31:2]);
  assign sel_con = (addr[31:2] == CON_ADDR[31:2]);
  assign con_wr  = wr && sel_con;

  assign tx_busy   = (tx_state != TX_IDLE);
  assign tx_finish = (tx_state == TX_STOP) && (tx_cnt == BAUD_LAST);
  assign rx_finish = (rx_state == RX_STOP) && !rx_ferr && (rx_cnt == BAUD_LAST) && rx_s2;

  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  // Load data mux; zero when not reading or address unmapped.
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_rxd)
        rdata = {24'b0, rxd};
      else if (sel_con)
        rdata = {27'b0, tx_busy, rx_ready, tx_done, con_rxie, con_txie};
    end
  end

  // Transmitter: start bit, 8 data bits LSB first, stop bit; tx is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (wr && sel_txd) begin
            tx_shift <= wdata[7:0];
            tx       <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // rx synchronizer plus one extra stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receiver: half-bit start check, centre sampling, stop-bit validation.
  // A bad stop bit parks in STOP (rx_ferr) until the line returns high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_ferr  <= 1'b0;
      rxd      <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_ferr  <= 1'b0;
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_ferr) begin
            if (rx_s2) begin
              rx_ferr  <= 1'b0;
              rx_state <= RX_IDLE;
            end
          end else if (rx_cnt == BAUD_LAST) begin
            rx_cnt <= '0;
            if (rx_s2) begin
              rxd      <= rx_shift;
              rx_state <= RX_IDLE;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // CON register: enables as written, sticky status where hardware set beats software clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      con_txie <= 1'b0;
      con_rxie <= 1'b0;
      tx_done  <= 1'b0;
      rx_ready <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (con_wr) begin
        con_txie <= wdata[0];
        con_rxie <= wdata[1];
      end
      tx_done  <= tx_finish | (tx_done  & ~(con_wr & ~wdata[2]));
      rx_ready <= rx_finish | (rx_ready & ~(con_wr & ~wdata[3]));
      irq      <= (con_txie & tx_done) | (con_rxie & rx_ready);
    end
  end

endmodule
